// File: rtl/scaled_sample_narrower.sv
// scaled_sample_narrower: saturates strobed 64-bit I/Q/sum triplets to OUT_W bits and buffers them in a FWFT FIFO with drop/saturation counters
module scaled_sample_narrower #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     M100CLK,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_strobe,
  input  logic [IN_W-1:0]          i_scaled,
  input  logic [IN_W-1:0]          q_scaled,
  input  logic [IN_W-1:0]          sum_scaled,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [OUT_W-1:0]         i_out,
  output logic [OUT_W-1:0]         q_out,
  output logic [OUT_W-1:0]         sum_out,
  output logic [2:0]               sat_flags,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         sat_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 * OUT_W + 3;
  // returns {flag, value}; overflow clamps toward the input's sign
  function automatic logic [OUT_W:0] narrow(input logic [IN_W-1:0] v);
    logic same;
    same = &v[IN_W-1:OUT_W-1] | ~|v[IN_W-1:OUT_W-1];
    return same ? {1'b0, v[OUT_W-1:0]} : {1'b1, v[IN_W-1], {(OUT_W-1){~v[IN_W-1]}}};
  endfunction
  logic [OUT_W:0] ni, nq, ns;
  logic           s1_valid;
  logic [EW-1:0]  s1_entry;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           full, pop, wr, drop, sat_inc;
  assign ni = narrow(i_scaled);
  assign nq = narrow(q_scaled);
  assign ns = narrow(sum_scaled);
  assign out_valid = fill_level != '0;
  assign full = fill_level == (AW+1)'(DEPTH);
  assign pop = out_valid & out_ack;
  assign wr = s1_valid & (~full | pop);
  assign drop = s1_valid & full & ~pop;
  assign sat_inc = wr & |s1_entry[EW-1:EW-3];
  assign {sat_flags, sum_out, q_out, i_out} = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= in_strobe;
      if (in_strobe) s1_entry <= {ns[OUT_W], nq[OUT_W], ni[OUT_W], ns[OUT_W-1:0], nq[OUT_W-1:0], ni[OUT_W-1:0]};
    end
  end
  always_ff @(posedge M100CLK) begin
    if (wr) mem[wr_ptr] <= s1_entry;
  end
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
      drop_count <= '0;
      sat_count <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fill_level <= fill_level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      drop_count <= clear ? '0 : (drop && ~&drop_count) ? drop_count + CNT_W'(1) : drop_count;
      sat_count <= clear ? '0 : (sat_inc && ~&sat_count) ? sat_count + CNT_W'(1) : sat_count;
    end
  end
endmodule

// File: tb/tb_scaled_sample_narrower.sv
// tb_scaled_sample_narrower: directed and random stimulus checked against a queue-based reference model
module tb_scaled_sample_narrower;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] s, q, i;
  } ent_t;
  logic M100CLK = 0, reset = 0, clear = 0, in_strobe = 0, out_ack = 0;
  logic [63:0] i_scaled = 0, q_scaled = 0, sum_scaled = 0;
  logic out_valid;
  logic [31:0] i_out, q_out, sum_out;
  logic [2:0] sat_flags;
  logic [3:0] fill_level;
  logic [CNT_W-1:0] drop_count, sat_count;
  int passed = 0, total = 0;
  ent_t mq[$];
  ent_t pend;
  bit pend_v = 0;
  int m_drop = 0, m_sat = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  scaled_sample_narrower #(.IN_W(64), .OUT_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .M100CLK(M100CLK), .reset(reset), .clear(clear), .in_strobe(in_strobe),
    .i_scaled(i_scaled), .q_scaled(q_scaled), .sum_scaled(sum_scaled),
    .out_valid(out_valid), .out_ack(out_ack), .i_out(i_out), .q_out(q_out),
    .sum_out(sum_out), .sat_flags(sat_flags), .fill_level(fill_level),
    .drop_count(drop_count), .sat_count(sat_count));

  always #5 M100CLK = ~M100CLK;

  function automatic logic [32:0] nar(input logic [63:0] v);
    longint s;
    s = v;
    if (s > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, v[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    ent_t h;
    h = mq.size() != 0 ? mq[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("fill_level", 64'(fill_level), 64'(mq.size()));
    chk("i_out", 64'(i_out), 64'(h.i));
    chk("q_out", 64'(q_out), 64'(h.q));
    chk("sum_out", 64'(sum_out), 64'(h.s));
    chk("sat_flags", 64'(sat_flags), 64'(h.f));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("sat_count", 64'(sat_count), 64'(m_sat));
  endtask

  task automatic step(input bit stb, input logic [63:0] iv, input logic [63:0] qv,
                      input logic [63:0] sv, input bit ack, input bit clr);
    logic [32:0] a, b, c;
    bit pop;
    in_strobe = stb; i_scaled = iv; q_scaled = qv; sum_scaled = sv; out_ack = ack; clear = clr;
    @(posedge M100CLK);
    pop = ack && mq.size() != 0;
    if (pend_v) begin
      if (mq.size() < DEPTH || pop) begin
        if (pop) void'(mq.pop_front());
        mq.push_back(pend);
        if (pend.f != 0 && m_sat < CMAX) m_sat++;
      end else begin
        if (m_drop < CMAX) m_drop++;
      end
    end else if (pop) void'(mq.pop_front());
    if (clr) begin m_drop = 0; m_sat = 0; end
    pend_v = stb;
    a = nar(iv); b = nar(qv); c = nar(sv);
    pend = '{f: {c[32], b[32], a[32]}, s: c[31:0], q: b[31:0], i: a[31:0]};
    #1 check_all();
  endtask

  function automatic logic [63:0] rnd64();
    logic [31:0] lo;
    lo = $urandom;
    case ($urandom_range(3))
      0: return {{32{lo[31]}}, lo};
      1: return {$urandom, $urandom};
      2: return {32'h0, lo};
      default: return {32'hFFFF_FFFF, lo};
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge M100CLK);
    #1 check_all();
    @(negedge M100CLK) reset = 1;
    // latency: single strobe with ack held high
    step(1, 64'h5, 64'h0, 64'h7, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("lat_valid", 64'(out_valid), 64'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("lat_gone", 64'(out_valid), 64'd0);
    // saturation cases
    step(1, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_8000_0000, 64'hFFFF_FFFE_0000_0000, 0, 0);
    step(1, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sat_q", 64'(q_out), 64'h7FFF_FFFF);
    chk("sat_sum", 64'(sum_out), 64'h8000_0000);
    chk("sat_fl", 64'(sat_flags), 64'b110);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    // overflow: 10 strobes with no ack
    for (int k = 1; k <= 10; k++) step(1, 64'(k), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ovf_drop", 64'(drop_count), 64'd2);
    chk("ovf_fill", 64'(fill_level), 64'd8);
    repeat (9) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    // full with simultaneous pop across pointer wrap
    for (int k = 0; k < 9; k++) step(1, 64'(100 + k), 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 64'(200 + k), 0, 0, 1, 0);
    chk("fp_drop", 64'(drop_count), 64'd0);
    repeat (10) step(0, 0, 0, 0, 1, 0);
    // counter saturation at all-ones, then clear coinciding with a saturating write
    for (int k = 0; k < 20; k++) step(1, 64'h1_0000_0000, 0, 0, 1, 0);
    chk("cnt_max", 64'(sat_count), 64'hF);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("clr_win", 64'(sat_count), 64'd0);
    // async reset between edges with entries stored and one in flight
    for (int k = 0; k < 4; k++) step(1, 64'(300 + k), 0, 0, 0, 0);
    #2 reset = 0;
    #1;
    mq.delete(); pend_v = 0; m_drop = 0; m_sat = 0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    @(negedge M100CLK) reset = 1;
    step(1, 64'h1234, 64'h5678, 64'h9ABC, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_i", 64'(i_out), 64'h1234);
    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(9) < 7, rnd64(), rnd64(), rnd64(), $urandom_range(9) < 5, $urandom_range(49) == 0);
    repeat (12) step(0, 0, 0, 0, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
